reservation_station_bank: RTL and testbench
===========================================

RESERVATION_STATION_BANK -- requirements
Module: reservation_station_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand data width.
REQ-002 SHALL have parameter TAG_WIDTH, default 5, ROB tag width; tag 0 = "operand present".
REQ-003 SHALL have parameter DEPTH, default 4, entry count (power of 2, >=2).
REQ-004 SHALL have parameter OP_WIDTH, default 3, ALU opcode width.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 flush  in  1  mispredict flush; active-high, synchronous.
REQ-008 dispatch_valid / dispatch_ready  in / out  1 / 1  dispatch handshake.
REQ-009 dispatch_rob_tag, dispatch_op, dispatch_op1_tag, dispatch_op1_data, dispatch_op2_tag, dispatch_op2_data  in  TAG_WIDTH/OP_WIDTH/TAG_WIDTH/XLEN/TAG_WIDTH/XLEN  incoming instruction.
REQ-010 cdb_enable, cdb_tag, cdb_data  in  1/TAG_WIDTH/XLEN  common data bus broadcast.
REQ-011 issue_valid / issue_ready  out / in  1 / 1  issue handshake to functional unit.
REQ-012 issue_rob_tag, issue_op, issue_op1_data, issue_op2_data  out  TAG_WIDTH/OP_WIDTH/XLEN/XLEN  selected instruction.
REQ-013 count  out  $clog2(DEPTH)+1  occupied entries; full, empty  out  1  status.

Function
REQ-014 Each entry SHALL hold busy, age, rob_tag, op, op1_tag/data, op2_tag/data.
REQ-015 dispatch_ready SHALL equal !full, using registered count only (no same-cycle reuse of an entry being issued).
REQ-016 Dispatch accept (dispatch_valid && dispatch_ready) SHALL write the lowest-index non-busy entry, set busy, set age = count.
REQ-017 On dispatch, an operand whose nonzero tag equals cdb_tag with cdb_enable SHALL store cdb_data and tag 0 (same-cycle bypass).
REQ-018 Every busy entry SHALL capture cdb_data and clear the matching operand tag when cdb_enable and nonzero tag == cdb_tag; tag 0 SHALL never match.
REQ-019 An entry SHALL be ready when busy and both registered tags are 0; CDB capture makes it ready the following cycle.
REQ-020 issue_valid SHALL be 1 iff any entry is ready; selection SHALL be the ready entry with the smallest age (oldest).
REQ-021 Issue outputs SHALL be combinational from registered state of the selected entry; 0 when issue_valid is 0.
REQ-022 issue_valid and issue outputs SHALL hold stable while issue_valid && !issue_ready, unless flush/reset.
REQ-023 Issue accept (issue_valid && issue_ready) SHALL clear the selected entry's busy; all busy entries with greater age SHALL decrement age by 1.
REQ-024 Simultaneous dispatch and issue accept SHALL net count unchanged; new entry age = count - 1.
REQ-025 Ages of busy entries SHALL always be a permutation of 0..count-1.
REQ-026 count SHALL update next cycle: +1 dispatch, -1 issue, 0 both; full = (count == DEPTH), empty = (count == 0).
REQ-027 flush SHALL clear all entries and count next cycle, overriding same-cycle dispatch, issue, and CDB capture.
REQ-028 Single-entry latency: dispatch with both tags 0 at cycle N -> issue_valid at N+1.

Reset
REQ-029 reset==0 at a clock edge SHALL clear all entry fields to 0 and count to 0, overriding every other input.
REQ-030 After reset: dispatch_ready=1, issue_valid=0, issue outputs=0, count=0, full=0, empty=1.
REQ-031 Reset mid-operation SHALL discard all held instructions; no issue in the cycle following reset.

Structure
REQ-032 Package rs_pkg SHALL hold the entry struct typedef and the tag-0 "present" constant.
REQ-033 Sub-module rs_entry (one slot: storage, CDB snoop, ready) SHALL be instantiated DEPTH times; select/age logic in top.

Verification
REQ-034 Reset, then dispatch tag 0 / data 5,7, op 3, rob 2 -> next cycle issue_valid=1, op1=5, op2=7, rob=2; issue_ready=1 -> empty=1.
REQ-035 Dispatch op1_tag=4; later cdb_enable, tag 4, data 0xAA -> issue_valid one cycle after CDB, op1=0xAA.
REQ-036 Dispatch op2_tag=6 in same cycle as CDB tag 6, data 9 -> entry stored with op2=9, issues next cycle.
REQ-037 Fill DEPTH=4 entries (rob 1..4) all waiting; dispatch_ready=0, full=1; release rob 3 then rob 1 by CDB in same cycle -> rob 1 issues first (oldest), then rob 3.
REQ-038 issue_ready=0 for 3 cycles with ready entry -> outputs stable; simultaneous dispatch+issue when count=2 -> count stays 2.
REQ-039 flush with 3 busy entries plus concurrent dispatch -> next cycle count=0, issue_valid=0, dispatched instruction dropped.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types for the reservation station bank: the per-slot entry record,
// the "operand present" tag value, and the CDB tag-match helper.
package rs_pkg;

  localparam int RS_XLEN      = 32;
  localparam int RS_TAG_WIDTH = 5;
  localparam int RS_OP_WIDTH  = 3;
  localparam int RS_DEPTH     = 4;
  localparam int RS_AGE_WIDTH = $clog2(RS_DEPTH);

  // Tag 0 means the operand value is already held in the entry.
  localparam logic [RS_TAG_WIDTH-1:0] TAG_PRESENT = '0;

  typedef struct packed {
    logic                    busy;
    logic [RS_AGE_WIDTH-1:0] age;
    logic [RS_TAG_WIDTH-1:0] rob_tag;
    logic [RS_OP_WIDTH-1:0]  op;
    logic [RS_TAG_WIDTH-1:0] op1_tag;
    logic [RS_XLEN-1:0]      op1_data;
    logic [RS_TAG_WIDTH-1:0] op2_tag;
    logic [RS_XLEN-1:0]      op2_data;
  } rs_entry_t;

  // A present operand (tag 0) can never be woken up by a broadcast.
  function automatic logic tag_hit(input logic [RS_TAG_WIDTH-1:0] tag,
                                   input logic                    cdb_enable,
                                   input logic [RS_TAG_WIDTH-1:0] cdb_tag);
    return cdb_enable && (tag != TAG_PRESENT) && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation station slot: holds a dispatched instruction, snoops the CDB
// for its missing operands and reports when both operands are present.
module rs_entry
  import rs_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    write_en,
  input  rs_entry_t               write_data,
  input  logic                    issue_clear,
  input  logic                    age_dec,
  input  logic                    cdb_enable,
  input  logic [RS_TAG_WIDTH-1:0] cdb_tag,
  input  logic [RS_XLEN-1:0]      cdb_data,
  output logic                    busy,
  output logic [RS_AGE_WIDTH-1:0] age,
  output logic [RS_TAG_WIDTH-1:0] rob_tag,
  output logic [RS_OP_WIDTH-1:0]  op,
  output logic [RS_XLEN-1:0]      op1_data,
  output logic [RS_XLEN-1:0]      op2_data,
  output logic                    ready
);

  rs_entry_t entry_q;
  logic      write_op1_hit;
  logic      write_op2_hit;
  logic      held_op1_hit;
  logic      held_op2_hit;

  assign write_op1_hit = tag_hit(write_data.op1_tag, cdb_enable, cdb_tag);
  assign write_op2_hit = tag_hit(write_data.op2_tag, cdb_enable, cdb_tag);
  assign held_op1_hit  = tag_hit(entry_q.op1_tag, cdb_enable, cdb_tag);
  assign held_op2_hit  = tag_hit(entry_q.op2_tag, cdb_enable, cdb_tag);

  // A write only ever targets a free slot and an issue only a busy one, so the
  // two branches below never compete for the same entry.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      entry_q <= '0;
    end else if (write_en) begin
      entry_q <= write_data;
      if (write_op1_hit) begin
        entry_q.op1_tag  <= TAG_PRESENT;
        entry_q.op1_data <= cdb_data;
      end
      if (write_op2_hit) begin
        entry_q.op2_tag  <= TAG_PRESENT;
        entry_q.op2_data <= cdb_data;
      end
    end else if (entry_q.busy) begin
      if (issue_clear) begin
        entry_q <= '0;
      end else begin
        if (age_dec) begin
          entry_q.age <= entry_q.age - 1'b1;
        end
        if (held_op1_hit) begin
          entry_q.op1_tag  <= TAG_PRESENT;
          entry_q.op1_data <= cdb_data;
        end
        if (held_op2_hit) begin
          entry_q.op2_tag  <= TAG_PRESENT;
          entry_q.op2_data <= cdb_data;
        end
      end
    end
  end

  assign busy     = entry_q.busy;
  assign age      = entry_q.age;
  assign rob_tag  = entry_q.rob_tag;
  assign op       = entry_q.op;
  assign op1_data = entry_q.op1_data;
  assign op2_data = entry_q.op2_data;
  assign ready    = entry_q.busy && (entry_q.op1_tag == TAG_PRESENT)
                    && (entry_q.op2_tag == TAG_PRESENT);

endmodule

// File: rtl/reservation_station_bank.sv
// Reservation station bank: DEPTH rs_entry slots with lowest-free-slot
// dispatch, oldest-ready issue selection and age compaction on issue.
module reservation_station_bank
  import rs_pkg::*;
#(
  parameter int XLEN      = RS_XLEN,
  parameter int TAG_WIDTH = RS_TAG_WIDTH,
  parameter int DEPTH     = RS_DEPTH,
  parameter int OP_WIDTH  = RS_OP_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [TAG_WIDTH-1:0]       dispatch_rob_tag,
  input  logic [OP_WIDTH-1:0]        dispatch_op,
  input  logic [TAG_WIDTH-1:0]       dispatch_op1_tag,
  input  logic [XLEN-1:0]            dispatch_op1_data,
  input  logic [TAG_WIDTH-1:0]       dispatch_op2_tag,
  input  logic [XLEN-1:0]            dispatch_op2_data,
  input  logic                       cdb_enable,
  input  logic [TAG_WIDTH-1:0]       cdb_tag,
  input  logic [XLEN-1:0]            cdb_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [TAG_WIDTH-1:0]       issue_rob_tag,
  output logic [OP_WIDTH-1:0]        issue_op,
  output logic [XLEN-1:0]            issue_op1_data,
  output logic [XLEN-1:0]            issue_op2_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]        busy_vec;
  logic [DEPTH-1:0]        ready_vec;
  logic [DEPTH-1:0]        write_en_vec;
  logic [DEPTH-1:0]        issue_clear_vec;
  logic [DEPTH-1:0]        age_dec_vec;
  logic [RS_AGE_WIDTH-1:0] age_a      [DEPTH];
  logic [RS_TAG_WIDTH-1:0] rob_tag_a  [DEPTH];
  logic [RS_OP_WIDTH-1:0]  op_a       [DEPTH];
  logic [RS_XLEN-1:0]      op1_data_a [DEPTH];
  logic [RS_XLEN-1:0]      op2_data_a [DEPTH];

  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_next;
  logic                    hold_q;
  logic [IDX_W-1:0]        hold_idx_q;

  logic                    free_found;
  logic [IDX_W-1:0]        free_idx;
  logic                    oldest_found;
  logic [IDX_W-1:0]        oldest_idx;
  logic [RS_AGE_WIDTH-1:0] oldest_age;
  logic [IDX_W-1:0]        sel_idx;
  logic [RS_AGE_WIDTH-1:0] sel_age;
  logic                    dispatch_fire;
  logic                    issue_fire;
  logic [RS_AGE_WIDTH-1:0] new_age;
  rs_entry_t               write_data;

  assign full           = (count_q == CNT_W'(DEPTH));
  assign empty          = (count_q == '0);
  assign count          = count_q;
  assign dispatch_ready = !full;

  // Lowest-index free slot (descending scan so the lowest index wins) and
  // oldest ready slot; ages of busy slots are unique, so the minimum is exact.
  always_comb begin
    free_found   = 1'b0;
    free_idx     = '0;
    oldest_found = 1'b0;
    oldest_idx   = '0;
    oldest_age   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_vec[i] && (!oldest_found || (age_a[i] < oldest_age))) begin
        oldest_found = 1'b1;
        oldest_idx   = IDX_W'(i);
        oldest_age   = age_a[i];
      end
    end
  end

  // A stalled issue keeps presenting the same slot even if an older slot
  // becomes ready meanwhile, so the functional unit sees stable outputs.
  assign sel_idx     = hold_q ? hold_idx_q : oldest_idx;
  assign sel_age     = age_a[sel_idx];
  assign issue_valid = hold_q ? ready_vec[hold_idx_q] : oldest_found;

  assign dispatch_fire = dispatch_valid && dispatch_ready;
  assign issue_fire    = issue_valid && issue_ready;

  assign issue_rob_tag  = issue_valid ? rob_tag_a[sel_idx]  : '0;
  assign issue_op       = issue_valid ? op_a[sel_idx]       : '0;
  assign issue_op1_data = issue_valid ? op1_data_a[sel_idx] : '0;
  assign issue_op2_data = issue_valid ? op2_data_a[sel_idx] : '0;

  // The slot leaving this cycle frees one age, so a concurrent newcomer takes count-1.
  assign new_age = issue_fire ? RS_AGE_WIDTH'(count_q - CNT_W'(1))
                              : RS_AGE_WIDTH'(count_q);

  always_comb begin
    write_data          = '0;
    write_data.busy     = 1'b1;
    write_data.age      = new_age;
    write_data.rob_tag  = dispatch_rob_tag;
    write_data.op       = dispatch_op;
    write_data.op1_tag  = dispatch_op1_tag;
    write_data.op1_data = dispatch_op1_data;
    write_data.op2_tag  = dispatch_op2_tag;
    write_data.op2_data = dispatch_op2_data;
  end

  always_comb begin
    write_en_vec    = '0;
    issue_clear_vec = '0;
    age_dec_vec     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      write_en_vec[i]    = dispatch_fire && free_found && (free_idx == IDX_W'(i));
      issue_clear_vec[i] = issue_fire && (sel_idx == IDX_W'(i));
      age_dec_vec[i]     = issue_fire && busy_vec[i] && (age_a[i] > sel_age);
    end
  end

  always_comb begin
    count_next = count_q;
    case ({dispatch_fire, issue_fire})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      count_q    <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      count_q    <= count_next;
      hold_q     <= issue_valid && !issue_ready;
      hold_idx_q <= sel_idx;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    rs_entry u_entry (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .write_en    (write_en_vec[g]),
      .write_data  (write_data),
      .issue_clear (issue_clear_vec[g]),
      .age_dec     (age_dec_vec[g]),
      .cdb_enable  (cdb_enable),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .busy        (busy_vec[g]),
      .age         (age_a[g]),
      .rob_tag     (rob_tag_a[g]),
      .op          (op_a[g]),
      .op1_data    (op1_data_a[g]),
      .op2_data    (op2_data_a[g]),
      .ready       (ready_vec[g])
    );
  end

endmodule

// File: tb/tb_reservation_station_bank.sv
// Directed bench for reservation_station_bank: stimulus pushes expected issues
// into a scoreboard queue, a negedge monitor pops and compares on each issue.
module tb_reservation_station_bank;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [4:0]  dispatch_rob_tag;
  logic [2:0]  dispatch_op;
  logic [4:0]  dispatch_op1_tag;
  logic [31:0] dispatch_op1_data;
  logic [4:0]  dispatch_op2_tag;
  logic [31:0] dispatch_op2_data;
  logic        cdb_enable;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rob_tag;
  logic [2:0]  issue_op;
  logic [31:0] issue_op1_data;
  logic [31:0] issue_op2_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  typedef struct {
    logic [4:0]  rob;
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  reservation_station_bank dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_rob_tag  (dispatch_rob_tag),
    .dispatch_op       (dispatch_op),
    .dispatch_op1_tag  (dispatch_op1_tag),
    .dispatch_op1_data (dispatch_op1_data),
    .dispatch_op2_tag  (dispatch_op2_tag),
    .dispatch_op2_data (dispatch_op2_data),
    .cdb_enable        (cdb_enable),
    .cdb_tag           (cdb_tag),
    .cdb_data          (cdb_data),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_rob_tag     (issue_rob_tag),
    .issue_op          (issue_op),
    .issue_op1_data    (issue_op1_data),
    .issue_op2_data    (issue_op2_data),
    .count             (count),
    .full              (full),
    .empty             (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of dispatch and CDB activity, then idles them again.
  task automatic applyStimulus(input logic dv, input logic [4:0] rob, input logic [2:0] op,
                               input logic [4:0] t1, input logic [31:0] d1,
                               input logic [4:0] t2, input logic [31:0] d2,
                               input logic ce, input logic [4:0] ct, input logic [31:0] cd);
    dispatch_valid    = dv;
    dispatch_rob_tag  = rob;
    dispatch_op       = op;
    dispatch_op1_tag  = t1;
    dispatch_op1_data = d1;
    dispatch_op2_tag  = t2;
    dispatch_op2_data = d2;
    cdb_enable        = ce;
    cdb_tag           = ct;
    cdb_data          = cd;
    tick();
    dispatch_valid = 1'b0;
    cdb_enable     = 1'b0;
  endtask

  task automatic expectIssue(input logic [4:0] rob, input logic [2:0] op,
                             input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e.rob = rob;
    e.op  = op;
    e.d1  = d1;
    e.d2  = d2;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_issue actual rob=%0d required no issue", issue_rob_tag);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("issue_rob", 32'(issue_rob_tag), 32'(mon_e.rob));
        checkOutput("issue_op", 32'(issue_op), 32'(mon_e.op));
        checkOutput("issue_op1", issue_op1_data, mon_e.d1);
        checkOutput("issue_op2", issue_op2_data, mon_e.d2);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; issue_ready = 1'b0;
    dispatch_valid = 1'b0; dispatch_rob_tag = '0; dispatch_op = '0;
    dispatch_op1_tag = '0; dispatch_op1_data = '0;
    dispatch_op2_tag = '0; dispatch_op2_data = '0;
    cdb_enable = 1'b0; cdb_tag = '0; cdb_data = '0;
    tick();
    tick();
    reset = 1'b1;
    checkOutput("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    checkOutput("rst_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("rst_issue_rob", 32'(issue_rob_tag), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);

    // Single ready instruction: visible one cycle after dispatch.
    applyStimulus(1, 5'd2, 3'd3, 5'd0, 32'd5, 5'd0, 32'd7, 0, 5'd0, 32'd0);
    checkOutput("lat_issue_valid", 32'(issue_valid), 32'd1);
    checkOutput("lat_count", 32'(count), 32'd1);
    expectIssue(5'd2, 3'd3, 32'd5, 32'd7);
    issue_ready = 1'b1;
    drain();
    issue_ready = 1'b0;
    checkOutput("lat_empty", 32'(empty), 32'd1);

    // Operand waiting on tag 4, woken by a later broadcast.
    applyStimulus(1, 5'd5, 3'd1, 5'd4, 32'd0, 5'd0, 32'h33, 0, 5'd0, 32'd0);
    checkOutput("wait_valid0", 32'(issue_valid), 32'd0);
    tick();
    checkOutput("wait_valid1", 32'(issue_valid), 32'd0);
    applyStimulus(0, 5'd0, 3'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1, 5'd4, 32'hAA);
    checkOutput("cdb_wake_valid", 32'(issue_valid), 32'd1);
    expectIssue(5'd5, 3'd1, 32'hAA, 32'h33);
    issue_ready = 1'b1;
    drain();
    issue_ready = 1'b0;

    // Same-cycle bypass on op2.
    applyStimulus(1, 5'd6, 3'd2, 5'd0, 32'h11, 5'd6, 32'hDEAD, 1, 5'd6, 32'd9);
    checkOutput("bypass_valid", 32'(issue_valid), 32'd1);
    expectIssue(5'd6, 3'd2, 32'h11, 32'd9);
    issue_ready = 1'b1;
    drain();
    issue_ready = 1'b0;

    // A tag-0 broadcast must neither bypass nor overwrite a present operand.
    applyStimulus(1, 5'd7, 3'd5, 5'd0, 32'h21, 5'd3, 32'd0, 1, 5'd0, 32'hFF);
    checkOutput("tag0_valid", 32'(issue_valid), 32'd0);
    applyStimulus(0, 5'd0, 3'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1, 5'd0, 32'hFF);
    applyStimulus(0, 5'd0, 3'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1, 5'd3, 32'h44);
    expectIssue(5'd7, 3'd5, 32'h21, 32'h44);
    issue_ready = 1'b1;
    drain();
    issue_ready = 1'b0;

    // Fill all four slots, each waiting on tag 7 or 8.
    applyStimulus(1, 5'd1, 3'd4, 5'd7, 32'd0, 5'd0, 32'h10, 0, 5'd0, 32'd0);
    applyStimulus(1, 5'd2, 3'd5, 5'd8, 32'd0, 5'd0, 32'h20, 0, 5'd0, 32'd0);
    applyStimulus(1, 5'd3, 3'd6, 5'd7, 32'd0, 5'd0, 32'h30, 0, 5'd0, 32'd0);
    applyStimulus(1, 5'd4, 3'd7, 5'd8, 32'd0, 5'd0, 32'h40, 0, 5'd0, 32'd0);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_dispatch_ready", 32'(dispatch_ready), 32'd0);
    applyStimulus(1, 5'd9, 3'd1, 5'd0, 32'd1, 5'd0, 32'd1, 0, 5'd0, 32'd0);
    checkOutput("full_drop_count", 32'(count), 32'd4);
    applyStimulus(0, 5'd0, 3'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1, 5'd7, 32'h77);
    expectIssue(5'd1, 3'd4, 32'h77, 32'h10);
    expectIssue(5'd3, 3'd6, 32'h77, 32'h30);
    for (int s = 0; s < 3; s++) begin
      checkOutput("stall_valid", 32'(issue_valid), 32'd1);
      checkOutput("stall_rob", 32'(issue_rob_tag), 32'd1);
      checkOutput("stall_op1", issue_op1_data, 32'h77);
      tick();
    end
    issue_ready = 1'b1;
    tick();
    tick();
    issue_ready = 1'b0;
    checkOutput("after_two_count", 32'(count), 32'd2);
    checkOutput("after_two_valid", 32'(issue_valid), 32'd0);
    drain();

    // Concurrent dispatch and issue at count 2 keeps count at 2.
    applyStimulus(0, 5'd0, 3'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1, 5'd8, 32'h88);
    checkOutput("oldest_rob2", 32'(issue_rob_tag), 32'd2);
    expectIssue(5'd2, 3'd5, 32'h88, 32'h20);
    expectIssue(5'd4, 3'd7, 32'h88, 32'h40);
    expectIssue(5'd10, 3'd0, 32'd1, 32'd2);
    issue_ready = 1'b1;
    applyStimulus(1, 5'd10, 3'd0, 5'd0, 32'd1, 5'd0, 32'd2, 0, 5'd0, 32'd0);
    checkOutput("both_count", 32'(count), 32'd2);
    drain();
    issue_ready = 1'b0;

    // Flush with three busy slots and a concurrent dispatch and broadcast.
    applyStimulus(1, 5'd11, 3'd1, 5'd9, 32'd0, 5'd0, 32'd1, 0, 5'd0, 32'd0);
    applyStimulus(1, 5'd12, 3'd2, 5'd9, 32'd0, 5'd0, 32'd2, 0, 5'd0, 32'd0);
    applyStimulus(1, 5'd13, 3'd3, 5'd9, 32'd0, 5'd0, 32'd3, 0, 5'd0, 32'd0);
    checkOutput("preflush_count", 32'(count), 32'd3);
    flush = 1'b1;
    issue_ready = 1'b1;
    applyStimulus(1, 5'd15, 3'd1, 5'd0, 32'h55, 5'd0, 32'h66, 1, 5'd9, 32'h99);
    flush = 1'b0;
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_valid", 32'(issue_valid), 32'd0);
    checkOutput("flush_empty", 32'(empty), 32'd1);
    tick();
    tick();
    checkOutput("flush_idle_valid", 32'(issue_valid), 32'd0);
    issue_ready = 1'b0;

    // Reset mid-operation discards held instructions.
    applyStimulus(1, 5'd20, 3'd2, 5'd0, 32'h1, 5'd0, 32'h2, 0, 5'd0, 32'd0);
    applyStimulus(1, 5'd21, 3'd3, 5'd0, 32'h3, 5'd0, 32'h4, 0, 5'd0, 32'd0);
    checkOutput("prereset_valid", 32'(issue_valid), 32'd1);
    reset = 1'b0;
    applyStimulus(1, 5'd22, 3'd4, 5'd0, 32'h5, 5'd0, 32'h6, 0, 5'd0, 32'd0);
    reset = 1'b1;
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_valid", 32'(issue_valid), 32'd0);
    checkOutput("midrst_rob", 32'(issue_rob_tag), 32'd0);
    checkOutput("midrst_op1", issue_op1_data, 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    issue_ready = 1'b1;
    tick();
    tick();
    checkOutput("midrst_idle_valid", 32'(issue_valid), 32'd0);
    issue_ready = 1'b0;

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
